muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 165 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension multiply/divide unit: one shared shift/add-subtract
// datapath, one iteration per cycle, with a combinational stall back to EX.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q, result_q;
    logic             neg_q, spec_q;

    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, spec_val;
    logic             div_zero, ovf, special, neg_start, accept;

    logic [WIDTH:0]   add_sum, rem_shift, rem_diff;
    logic [WIDTH-1:0] hi_n, lo_n;

    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   div_raw, div_s, final_res;

    // Operand decode at start: magnitudes, sign bookkeeping and early-out cases
    always_comb begin
        a_signed  = (i_op == 3'd1) | (i_op == 3'd2) | (i_op == 3'd4) | (i_op == 3'd6);
        b_signed  = (i_op == 3'd1) | (i_op == 3'd4) | (i_op == 3'd6);
        a_neg     = a_signed & i_a[WIDTH-1];
        b_neg     = b_signed & i_b[WIDTH-1];
        a_mag     = a_neg ? -i_a : i_a;
        b_mag     = b_neg ? -i_b : i_b;
        div_zero  = i_op[2] & (i_b == '0);
        ovf       = i_op[2] & ~i_op[0] & (i_a == MIN_VAL) & (i_b == '1);
        special   = div_zero | ovf;
        if (div_zero) begin
            spec_val = i_op[1] ? i_a : '1;
        end else begin
            spec_val = i_op[1] ? '0 : MIN_VAL;
        end
        // Remainder follows the dividend; everything else follows the sign product
        neg_start = (i_op[2] & i_op[1]) ? a_neg : (a_neg ^ b_neg);
        accept    = (state_q == IDLE) & i_start & ~i_flush;
    end

    // One iteration: multiply shifts {hi,lo} right, divide shifts left and restores
    always_comb begin
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        if (op_q[2]) begin
            if (!rem_diff[WIDTH]) begin
                hi_n = rem_diff[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = rem_shift[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = add_sum[WIDTH:1];
            lo_n = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod    = {hi_q, lo_q};
        prod_s  = neg_q ? -prod : prod;
        div_raw = op_q[1] ? hi_q : lo_q;
        div_s   = neg_q ? -div_raw : div_raw;
        if (spec_q) begin
            final_res = hi_q;
        end else if (op_q[2]) begin
            final_res = div_s;
        end else if (op_q[1:0] == 2'd0) begin
            final_res = prod_s[WIDTH-1:0];
        end else begin
            final_res = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state_q != IDLE);
        o_done   = (state_q == DONE) & ~i_flush;
        o_stall  = i_start & ~o_done;
        o_result = (state_q == DONE) ? final_res : result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt_q  <= CNT_INIT;
                op_q   <= i_op;
                hi_q   <= special ? spec_val : '0;
                lo_q   <= a_mag;
                b_q    <= b_mag;
                neg_q  <= neg_start;
                spec_q <= special;
            end else if (state_q == CALC) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
            // A flush during the result cycle discards the result
            if ((state_q == DONE) && !i_flush) begin
                result_q <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized checks of muldiv_seq against an arithmetic reference
// model for all eight M-extension operations, flush and reset behaviour.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_flush;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic        o_stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result),
        .o_stall  (o_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0]        ua, ub, p;
        longint             sa, sb;
        logic signed [31:0] a32, b32;
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        a32 = a;
        b32 = b;
        sa  = longint'(a32);
        sb  = longint'(b32);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(a32 / b32);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(a32 % b32);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Runs one operation starting in the current cycle; leaves the bench in the
    // idle cycle after completion, ready for a back-to-back start.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble);
        logic [31:0] exp;
        int          stalls;
        int          exp_stalls;
        bit          seen;
        bit          special;
        exp        = ref_model(op, a, b);
        special    = (op[2] && b == 32'd0) ||
                     ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp_stalls = special ? 1 : 33;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        stalls  = 0;
        seen    = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            if (o_stall) stalls++;
            if (c == 1) check("busy_mid", 64'(o_busy), 64'd1);
            @(negedge clk);
            if (scramble && c == 0) begin
                i_a  = $urandom;
                i_b  = $urandom;
                i_op = 3'($urandom_range(0, 7));
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("result", 64'(o_result), 64'(exp));
        check("stall_cycles", 64'(stalls), 64'(exp_stalls));
        i_start = 1'b0;
        $display("op=%0d a=%h b=%h result=%h expected=%h stall_cycles=%0d",
                 op, a, b, o_result, exp, stalls);
        @(negedge clk);
        #1;
        check("result_hold", 64'(o_result), 64'(exp));
        check("done_low", 64'(o_done), 64'd0);
        check("idle_after", 64'(o_busy), 64'd0);
        last_result = exp;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst     = 1'b1;
        i_start = 1'b0;
        i_op    = 3'd0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        i_flush = 1'b0;
        last_result = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_stall", 64'(o_stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'd6, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 1'b0);
        run_op(3'd5, 32'd5, 32'd0, 1'b0);
        run_op(3'd6, 32'd5, 32'd0, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Flush in the middle of a divide
        i_op = 3'd4; i_a = 32'd1000; i_b = 32'd3; i_start = 1'b1;
        repeat (11) @(negedge clk);
        i_flush = 1'b1;
        i_start = 1'b0;
        #1;
        check("flush_no_done", 64'(o_done), 64'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("flush_idle", 64'(o_busy), 64'd0);
        check("flush_result_kept", 64'(o_result), 64'(last_result));
        @(negedge clk);
        run_op(3'd0, 32'd3, 32'd3, 1'b0);

        // Flush landing on the result cycle of an early-out divide
        i_op = 3'd5; i_a = 32'd5; i_b = 32'd0; i_start = 1'b1;
        @(negedge clk);
        i_flush = 1'b1;
        #1;
        check("flush_done_masked", 64'(o_done), 64'd0);
        i_start = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("flush_done_idle", 64'(o_busy), 64'd0);
        check("flush_done_result", 64'(o_result), 64'(last_result));

        // Start together with flush in IDLE must not begin an operation
        i_op = 3'd0; i_a = 32'd2; i_b = 32'd2; i_start = 1'b1; i_flush = 1'b1;
        @(negedge clk);
        #1;
        check("start_flush_idle", 64'(o_busy), 64'd0);
        i_start = 1'b0;
        i_flush = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case (n % 5)
                1: rb = rb & 32'h0000_00FF;
                2: ra = ra & 32'h0000_FFFF;
                3: if (n % 10 == 3) rb = 32'd0;
                default: ;
            endcase
            run_op(rop, ra, rb, 1'b1);
        end

        // Reset during CALC, then hold start while reset is asserted
        i_op = 3'd0; i_a = 32'd5; i_b = 32'd5; i_start = 1'b1;
        repeat (5) @(negedge clk);
        rst     = 1'b1;
        i_start = 1'b0;
        @(negedge clk);
        #1;
        check("rst_calc_busy", 64'(o_busy), 64'd0);
        check("rst_calc_done", 64'(o_done), 64'd0);
        check("rst_calc_result", 64'(o_result), 64'd0);
        check("rst_calc_stall", 64'(o_stall), 64'd0);
        i_op = 3'd0; i_a = 32'd7; i_b = 32'd6; i_start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("rst_hold_busy", 64'(o_busy), 64'd0);
            check("rst_hold_done", 64'(o_done), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, 32'd7, 32'd6, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
